// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: Status/Cause/EPC registers, exception entry and rfe return.
// Optional Status.IM interrupt masking is compiled in when CP0_IM_EN is defined.
module cp0_exc_ctrl #(
  parameter logic [31:0] RESET_VECTOR_BEV = 32'hBFC00180,
  parameter logic [31:0] EXC_VECTOR       = 32'h80000080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pendingexception,
  input  logic [4:0]  exccode,
  input  logic [31:0] pc,
  input  logic        in_delay_slot,
  input  logic        rfe,
  input  logic [5:0]  irq_in,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] mtc0_wdata,
  output logic [31:0] mfc0_rdata,
  output logic [7:0]  interrupts,
  output logic        iec,
  output logic        exc_redirect,
  output logic [31:0] exc_target,
  output logic        flush,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXC_REDIR, RFE_REDIR} state_t;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  state_t      state, state_nxt;
  logic [5:0]  status_ieku;
  logic        status_bev;
  logic [7:0]  status_im;
  logic        cause_bd;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic [31:0] epc;
  logic [7:0]  cause_ip;
  logic [31:0] status_word, cause_word;

`ifndef CP0_IM_EN
  assign status_im = 8'h00;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pendingexception) state_nxt = EXC_REDIR;
        else if (rfe)         state_nxt = RFE_REDIR;
      end
      EXC_REDIR: state_nxt = IDLE;
      RFE_REDIR: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      status_ieku   <= 6'b0;
      status_bev    <= 1'b1;
`ifdef CP0_IM_EN
      status_im     <= 8'h00;
`endif
      cause_bd      <= 1'b0;
      cause_ip_sw   <= 2'b0;
      cause_exccode <= 5'b0;
      epc           <= 32'h0;
    end else begin
      state <= state_nxt;
      // Only IDLE accepts events; priority is exception, then rfe, then mtc0.
      if (state == IDLE) begin
        if (pendingexception) begin
          epc           <= in_delay_slot ? pc - 32'd4 : pc;
          cause_bd      <= in_delay_slot;
          cause_exccode <= exccode;
          status_ieku   <= {status_ieku[3:0], 2'b00};
        end else if (rfe) begin
          status_ieku   <= {status_ieku[5:4], status_ieku[5:2]};
        end else if (mtc0_we) begin
          case (cp0_addr)
            ADDR_STATUS: begin
              status_ieku <= mtc0_wdata[5:0];
              status_bev  <= mtc0_wdata[22];
`ifdef CP0_IM_EN
              status_im   <= mtc0_wdata[15:8];
`endif
            end
            ADDR_CAUSE: cause_ip_sw <= mtc0_wdata[9:8];
            ADDR_EPC:   epc         <= mtc0_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  assign cause_ip    = {irq_in, cause_ip_sw};
  assign status_word = {9'b0, status_bev, 6'b0, status_im, 2'b0, status_ieku};
  assign cause_word  = {cause_bd, 15'b0, cause_ip, 1'b0, cause_exccode, 2'b0};

  always_comb begin
    case (cp0_addr)
      ADDR_STATUS: mfc0_rdata = status_word;
      ADDR_CAUSE:  mfc0_rdata = cause_word;
      ADDR_EPC:    mfc0_rdata = epc;
      default:     mfc0_rdata = 32'h0;
    endcase
  end

`ifdef CP0_IM_EN
  assign interrupts = cause_ip & status_im;
`else
  assign interrupts = cause_ip;
`endif

  assign iec          = status_ieku[0];
  assign busy         = (state != IDLE);
  assign exc_redirect = busy;
  assign flush        = busy;
  // BEV cannot change during EXC_REDIR, so the vector reflects the value at entry.
  assign exc_target   = (state == EXC_REDIR) ? (status_bev ? RESET_VECTOR_BEV : EXC_VECTOR) : epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a register-level reference model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] BEV_VEC = 32'hBFC00180;
  localparam logic [31:0] EXC_VEC = 32'h80000080;
`ifdef CP0_IM_EN
  localparam logic [31:0] STATUS_WMASK = 32'h0040FF3F;
  localparam bit          IM_EN = 1'b1;
`else
  localparam logic [31:0] STATUS_WMASK = 32'h0040003F;
  localparam bit          IM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pendingexception = 1'b0;
  logic [4:0]  exccode = '0;
  logic [31:0] pc = '0;
  logic        in_delay_slot = 1'b0;
  logic        rfe = 1'b0;
  logic [5:0]  irq_in = '0;
  logic        mtc0_we = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] mtc0_wdata = '0;
  logic [31:0] mfc0_rdata;
  logic [7:0]  interrupts;
  logic        iec, exc_redirect, flush, busy;
  logic [31:0] exc_target;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents plus an outstanding redirect.
  logic [31:0] m_status, m_epc, m_target;
  logic        m_bd, m_pend;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .pendingexception(pendingexception), .exccode(exccode),
    .pc(pc), .in_delay_slot(in_delay_slot), .rfe(rfe), .irq_in(irq_in),
    .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_rdata(mfc0_rdata), .interrupts(interrupts), .iec(iec),
    .exc_redirect(exc_redirect), .exc_target(exc_target), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_status = 32'h00400000;
    m_epc = '0; m_target = '0; m_bd = 1'b0; m_pend = 1'b0; m_ipsw = '0; m_exc = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_status;
      5'd13:   return {m_bd, 15'b0, irq_in, m_ipsw, 1'b0, m_exc, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    if (reset) model_reset();
    else if (m_pend) m_pend = 1'b0;
    else if (pendingexception) begin
      m_epc = in_delay_slot ? pc - 32'd4 : pc;
      m_bd = in_delay_slot;
      m_exc = exccode;
      m_status[5:0] = {m_status[3:0], 2'b00};
      m_target = m_status[22] ? BEV_VEC : EXC_VEC;
      m_pend = 1'b1;
    end else if (rfe) begin
      m_status[5:0] = {m_status[5:4], m_status[5:2]};
      m_target = m_epc;
      m_pend = 1'b1;
    end else if (mtc0_we) begin
      if (cp0_addr == 5'd12) m_status = (mtc0_wdata & STATUS_WMASK) | (m_status & ~STATUS_WMASK);
      else if (cp0_addr == 5'd13) m_ipsw = mtc0_wdata[9:8];
      else if (cp0_addr == 5'd14) m_epc = mtc0_wdata;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] ip;
    ip = {irq_in, m_ipsw};
    if (IM_EN) ip = ip & m_status[15:8];
    check("rdata", mfc0_rdata, model_read(cp0_addr));
    check("interrupts", {24'b0, interrupts}, {24'b0, ip});
    check("iec", {31'b0, iec}, {31'b0, m_status[0]});
    check("redirect", {31'b0, exc_redirect}, {31'b0, m_pend});
    check("flush", {31'b0, flush}, {31'b0, m_pend});
    check("busy", {31'b0, busy}, {31'b0, m_pend});
    if (m_pend) check("target", exc_target, m_target);
  endtask

  // Called at a negedge with inputs already applied: check, clock, advance model.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; pendingexception = 1'b0; rfe = 1'b0; mtc0_we = 1'b0;
    in_delay_slot = 1'b0; exccode = '0; mtc0_wdata = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1 d = mfc0_rdata;
  endtask

  task automatic take_exc(input logic [4:0] code, input logic [31:0] addr, input logic ds);
    pendingexception = 1'b1; exccode = code; pc = addr; in_delay_slot = ds;
    tick();
    idle_inputs();
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    idle_inputs();

    // Reset values
    rd(5'd12, d); check("rst_status", d, 32'h00400000);
    rd(5'd13, d); check("rst_cause", d, 32'h0);
    rd(5'd14, d); check("rst_epc", d, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_redirect", {31'b0, exc_redirect}, 32'h0);
    rd(5'd3, d); check("unimpl_read", d, 32'h0);

    // Syscall entry with BEV cleared
    mtc0_we = 1'b1; cp0_addr = 5'd12; mtc0_wdata = 32'h00000001;
    tick(); idle_inputs();
    take_exc(5'd8, 32'h00400020, 1'b0);
    check("sys_redirect", {31'b0, exc_redirect}, 32'h1);
    check("sys_target", exc_target, 32'h80000080);
    check("sys_iec", {31'b0, iec}, 32'h0);
    tick();
    check("sys_one_cycle", {31'b0, exc_redirect}, 32'h0);
    rd(5'd14, d); check("sys_epc", d, 32'h00400020);
    rd(5'd13, d); check("sys_cause", d, 32'h00000020);
    rd(5'd12, d); check("sys_status", d, 32'h00000004);

    // rfe returns to the saved PC and pops the mode stack
    rfe = 1'b1; tick(); idle_inputs();
    check("rfe_redirect", {31'b0, exc_redirect}, 32'h1);
    check("rfe_target", exc_target, 32'h00400020);
    tick();
    rd(5'd12, d); check("rfe_status", d, 32'h00000001);

    // Delay slot entries, including wraparound below zero
    take_exc(5'd0, 32'h00400004, 1'b1); tick();
    rd(5'd14, d); check("ds_epc", d, 32'h00400000);
    rd(5'd13, d); check("ds_cause", d, 32'h80000000);
    take_exc(5'd0, 32'h00000000, 1'b1); tick();
    rd(5'd14, d); check("ds_epc_wrap", d, 32'hFFFFFFFC);

    // Simultaneous exception, rfe and mtc0: only the exception lands; holding them causes no re-entry
    pendingexception = 1'b1; rfe = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd14;
    mtc0_wdata = 32'h12345678; exccode = 5'd4; pc = 32'h00000100; in_delay_slot = 1'b0;
    tick();
    check("sim_redirect", {31'b0, exc_redirect}, 32'h1);
    tick();
    idle_inputs();
    check("sim_no_reentry", {31'b0, busy}, 32'h0);
    rd(5'd14, d); check("sim_epc", d, 32'h00000100);
    rd(5'd13, d); check("sim_cause", d, 32'h00000010);

    // Interrupt masking
    irq_in = 6'b100000; cp0_addr = 5'd13;
    #1 check("irq_initial", {24'b0, interrupts}, IM_EN ? 32'h0 : 32'h80);
    mtc0_we = 1'b1; cp0_addr = 5'd12; mtc0_wdata = 32'h00008000;
    tick(); idle_inputs();
    check("irq_after_im", {24'b0, interrupts}, 32'h80);
    rd(5'd12, d); check("im_readback", d, IM_EN ? 32'h00008000 : 32'h0);
    irq_in = '0;

    // Reset in the middle of a redirect aborts it
    take_exc(5'd12, 32'h00001000, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_redirect", {31'b0, exc_redirect}, 32'h0);
    rd(5'd12, d); check("midrst_status", d, 32'h00400000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 99) == 0);
      pendingexception = ($urandom_range(0, 9) == 0);
      rfe              = ($urandom_range(0, 9) == 0);
      mtc0_we          = ($urandom_range(0, 2) == 0);
      exccode          = 5'($urandom);
      pc               = $urandom;
      in_delay_slot    = 1'($urandom);
      mtc0_wdata       = $urandom;
      if ($urandom_range(0, 7) == 0) irq_in = 6'($urandom);
      case ($urandom_range(0, 3))
        0:       cp0_addr = 5'd12;
        1:       cp0_addr = 5'd13;
        2:       cp0_addr = 5'd14;
        default: cp0_addr = 5'($urandom);
      endcase
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception controller: owns the Status, Cause and EPC registers and performs the exception-entry and return sequence. It sits around the combinational exception detector. Downstream, it consumes `pendingexception`/`exccode`; upstream, it supplies the detector's global enable (`iec`) and the masked interrupt lines. On an accepted exception it saves EPC, Cause and the Status mode stack, then issues a one-cycle PC redirect plus pipeline flush. On `rfe` it restores the mode stack and redirects to EPC.

## Interface
- `RESET_VECTOR_BEV`, 32'hBFC00180: exception vector used when Status.BEV=1.
- `EXC_VECTOR`, 32'h80000080: exception vector used when Status.BEV=0.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `pendingexception` in 1: from the exception detector.
- `exccode` in 5: from the exception detector; valid with `pendingexception`.
- `pc` in 32: address of the instruction taking the exception.
- `in_delay_slot` in 1: faulting instruction is in a branch delay slot.
- `rfe` in 1: return-from-exception instruction committing.
- `irq_in` in 6: external/timer hardware interrupt lines IP[7:2].
- `mtc0_we` in 1: CP0 write strobe.
- `cp0_addr` in 5: register number (12 Status, 13 Cause, 14 EPC); shared by read and write.
- `mtc0_wdata` in 32: write data.
- `mfc0_rdata` out 32: combinational read of `cp0_addr`; 0 for unimplemented numbers.
- `interrupts` out 8: Cause.IP[7:0], gated per Configuration; feeds the detector.
- `iec` out 1: Status.IEc.
- `exc_redirect` out 1: one-cycle PC load strobe.
- `exc_target` out 32: new PC, valid while `exc_redirect`=1.
- `flush` out 1: squash all in-flight instructions; asserted together with `exc_redirect`.
- `busy` out 1: high in any state other than IDLE; the front end stalls on it.

## Operation
- **Status (12):**
  - bit0 IEc, bit1 KUc, bit2 IEp, bit3 KUp, bit4 IEo, bit5 KUo.
  - bits[15:8] IM, bit22 BEV; all other bits read 0.
- **Cause (13):**
  - bit31 BD, bits[15:10] IP[7:2] (read-only live copy of `irq_in`), bits[9:8] IP[1:0] (software R/W), bits[6:2] ExcCode; others 0.
- **EPC (14):** 32-bit; software R/W.
- **FSM states:** IDLE, EXC_REDIR, RFE_REDIR.
- **IDLE, `pendingexception`=1:** exception is accepted. At the clock edge:
  - EPC <= `in_delay_slot` ? `pc`-4 : `pc` (mod 2^32).
  - Cause.BD <= `in_delay_slot`; Cause.ExcCode <= `exccode`.
  - Status[5:0] <= {Status[3:0], 2'b00}.
  - Next state EXC_REDIR.
- **EXC_REDIR:**
  - `exc_redirect`=`flush`=1; `exc_target` = BEV ? `RESET_VECTOR_BEV` : `EXC_VECTOR`.
  - Next state IDLE unconditionally.
- **IDLE, `rfe`=1, no exception:**
  - Status[5:0] <= {Status[5:4], Status[5:2]}.
  - Next state RFE_REDIR.
- **RFE_REDIR:**
  - `exc_redirect`=1, `flush`=1, `exc_target`=EPC (the value after any same-cycle updates).
  - Next state IDLE.
- **mtc0:** takes effect at the edge when `mtc0_we`=1 in IDLE. Read-only fields and writes to unimplemented numbers are ignored.
- **Priority in IDLE:** exception > rfe > mtc0; losers are dropped.
- **Outside IDLE:** `pendingexception`, `rfe` and `mtc0_we` are ignored.
- **Reset:** state IDLE; Status=32'h00400000 (BEV=1, all IE/KU 0); Cause=0; EPC=0. All outputs derive from these values, so after reset `exc_redirect`=`flush`=`busy`=`iec`=0 and `interrupts`=0 when `irq_in`=0.
- **Reset mid-sequence:** reset during EXC_REDIR or RFE_REDIR aborts the sequence and returns to IDLE with no redirect in the following cycle.

## Timing
- Exception latency: `pendingexception` sampled at edge N; `exc_redirect` high for exactly cycle N+1; first vector fetch at N+2.
- `iec` drops in cycle N+1, so the detector cannot re-raise an interrupt during the redirect.
- `rfe`: same one-cycle redirect, one cycle after the `rfe` edge.
- `mfc0_rdata`: zero latency; reflects a write in the cycle after the write edge.
- `busy` is high for exactly one cycle per exception or rfe.
- `irq_in` reaches `interrupts` combinationally, with no synchronizer; sources must already be in the `clk` domain.

## Configuration
- **`CP0_IM_EN` defined:**
  - `interrupts` = Cause.IP & Status.IM.
  - IM is writable and resets to 0.
- **`CP0_IM_EN` undefined:**
  - `interrupts` = Cause.IP, unmasked.
  - Status.IM reads 0 and writes to it are ignored.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** reset, then read via `cp0_addr` -> Status=32'h00400000, Cause=0, EPC=0; `busy`=`exc_redirect`=0.
- **Syscall entry:** mtc0 Status=32'h00000001; pulse `pendingexception` with `exccode`=8, `pc`=32'h00400020 -> next cycle redirect to 32'h80000080 (BEV=0); EPC=32'h00400020; Cause=32'h00000020; Status[5:0]=6'b000100; `iec`=0.
- **Delay slot:** `in_delay_slot`=1, `pc`=32'h00400004 -> EPC=32'h00400000, Cause.BD=1. Repeat with `pc`=0 -> EPC=32'hFFFFFFFC.
- **rfe after syscall:** Status[5:0] returns to 6'b000001; redirect target=32'h00400020.
- **Simultaneous events:** `pendingexception`, `rfe` and `mtc0_we` all asserted in the same cycle -> only the exception takes effect; inputs held high during EXC_REDIR cause no second entry.
- **Masking (`CP0_IM_EN` defined):** `irq_in`=6'b100000 (IP7) with IM=0 -> `interrupts`=0; after mtc0 IM=8'h80 -> `interrupts`=8'h80 the next cycle. Without the macro -> `interrupts`=8'h80 immediately.
